load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum REQ-state cycles to wait for bus_ack before abort.
REQ-002 SHALL have clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have nrst  input  1  reset: one clock; reset is synchronous and active-low.
REQ-004 SHALL have alu_result  input  32  effective byte address, the ALU result.
REQ-005 SHALL have store_data  input  32  rs2 value to store, low-order bits significant.
REQ-006 SHALL have mem_read, mem_write  input  1 each  single-cycle request strobes.
REQ-007 SHALL have size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have load_unsigned  input  1  1 = zero-extend loads, 0 = sign-extend.
REQ-009 SHALL have bus_rdata  input  32 and bus_ack  input  1  memory read data and completion.
REQ-010 SHALL have bus_addr  output  32, bus_wdata  output  32, bus_sel  output  4, bus_ren  output  1, bus_wen  output  1  memory request.
REQ-011 SHALL have load_data  output  32, done  output  1, load_valid  output  1, err  output  1, busy  output  1  pipeline-facing results.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, DONE; all outputs registered.
REQ-013 SHALL accept a request only in IDLE; strobes in REQ/DONE ignored.
REQ-014 SHALL give mem_write priority when mem_read and mem_write are both high; the read is dropped.
REQ-015 SHALL flag misaligned/illegal: half with addr[0]=1, word with addr[1:0]!=00, size=11.
REQ-016 SHALL, on misaligned/illegal request, issue no bus cycle, pulse err for one cycle next edge, stay IDLE.
REQ-017 SHALL, on a legal request, latch bus_addr = {alu_result[31:2],2'b00} and go to REQ next edge.
REQ-018 SHALL set bus_sel: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-019 SHALL set bus_wdata: byte replicated to all 4 lanes, half replicated to both halves, word unchanged.
REQ-020 SHALL hold bus_ren (read) or bus_wen (write) high and busy high for every REQ cycle; never both.
REQ-021 SHALL, on bus_ack sampled in REQ, drop strobes and enter DONE next edge.
REQ-022 SHALL pulse done for the single DONE cycle; load_valid also pulses there for reads only; DONE -> IDLE unconditionally.
REQ-023 SHALL extract load lane from bus_rdata at latched addr[1:0], sign- or zero-extend per latched size/load_unsigned, register into load_data at DONE entry.
REQ-024 SHALL hold load_data until the next completed load; writes leave it unchanged.
REQ-025 SHALL have minimum latency 2 edges: strobe at N, REQ at N+1 with ack, done at N+2.
REQ-026 SHALL count REQ cycles (8-bit+ counter, cleared on REQ entry); at TIMEOUT cycles without ack, drop strobes, pulse err one cycle, return IDLE, no done.
REQ-027 SHALL ignore bus_ack outside REQ.

Reset
REQ-028 SHALL, with nrst low at a rising edge, set state IDLE, counter 0, all outputs 0 including load_data.
REQ-029 SHALL, on reset mid-transaction, abort: strobes low after that edge, no done/err pulse.

Verification
REQ-030 SHALL cover: lw addr 0x100, ack first REQ cycle, bus_rdata 0xDEADBEEF -> bus_sel 1111, ren 1 cycle, done+load_valid at N+2, load_data 0xDEADBEEF.
REQ-031 SHALL cover: lb signed addr 0x103, rdata 0x80FF_FF7F -> bus_addr 0x100, sel 1000, load_data 0xFFFFFF80; lbu same -> 0x00000080.
REQ-032 SHALL cover: sh addr 0x202, store_data 0x0000ABCD, ack after 3 cycles -> bus_addr 0x200, sel 1100, wdata 0xABCDABCD, wen 3 cycles, done, no load_valid.
REQ-033 SHALL cover: lw addr 0x101 -> no ren/wen, err one cycle, busy 0, done 0.
REQ-034 SHALL cover: TIMEOUT=4, read with no ack -> ren exactly 4 cycles, then err pulse, IDLE, no done.
REQ-035 SHALL cover: nrst low during REQ with ren high -> ren/busy 0 after that edge, no done; read+write strobed together -> write only.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit between pipeline and memory bus
//
// Ports:
//   clk, nrst            clock, synchronous active-low reset
//   alu_result           effective byte address
//   store_data           store value (low-order bits significant)
//   mem_read, mem_write  single-cycle request strobes (write wins if both)
//   size                 00 byte, 01 half, 10 word, 11 illegal
//   load_unsigned        1 = zero-extend loads, 0 = sign-extend
//   bus_rdata, bus_ack   memory read data and completion
//   bus_addr, bus_wdata, bus_sel, bus_ren, bus_wen   memory request (registered)
//   load_data, done, load_valid, err, busy           pipeline results (registered)
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    output logic        bus_ren,
    output logic        bus_wen,
    output logic [31:0] load_data,
    output logic        done,
    output logic        load_valid,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    lat_off;
    logic [1:0]    lat_size;
    logic          lat_uns;
    logic          lat_read;

    logic          misaligned;
    logic [3:0]    sel_next;
    logic [31:0]   wdata_next;
    logic [7:0]    lane_byte;
    logic [15:0]   lane_half;
    logic [31:0]   load_ext;

    // Request decode from the live inputs, used only when accepting in IDLE.
    always_comb begin
        misaligned = 1'b0;
        sel_next   = 4'b1111;
        wdata_next = store_data;
        case (size)
            2'b00: begin
                sel_next   = 4'b0001 << alu_result[1:0];
                wdata_next = {4{store_data[7:0]}};
            end
            2'b01: begin
                misaligned = alu_result[0];
                sel_next   = 4'b0011 << alu_result[1:0];
                wdata_next = {2{store_data[15:0]}};
            end
            2'b10:   misaligned = |alu_result[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Load lane extraction uses the offset/size captured at request time,
    // since the pipeline inputs may have moved on while the bus is busy.
    always_comb begin
        lane_byte = bus_rdata[7:0];
        case (lat_off)
            2'b01:   lane_byte = bus_rdata[15:8];
            2'b10:   lane_byte = bus_rdata[23:16];
            2'b11:   lane_byte = bus_rdata[31:24];
            default: lane_byte = bus_rdata[7:0];
        endcase
        lane_half = lat_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (lat_size)
            2'b00:   load_ext = lat_uns ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            2'b01:   load_ext = lat_uns ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
            default: load_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_off    <= 2'b00;
            lat_size   <= 2'b00;
            lat_uns    <= 1'b0;
            lat_read   <= 1'b0;
            bus_addr   <= 32'b0;
            bus_wdata  <= 32'b0;
            bus_sel    <= 4'b0;
            bus_ren    <= 1'b0;
            bus_wen    <= 1'b0;
            load_data  <= 32'b0;
            done       <= 1'b0;
            load_valid <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // done/load_valid/err are one-cycle pulses by default
            done       <= 1'b0;
            load_valid <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        if (misaligned) begin
                            err <= 1'b1;
                        end else begin
                            state     <= REQ;
                            cnt       <= '0;
                            bus_addr  <= {alu_result[31:2], 2'b00};
                            bus_sel   <= sel_next;
                            bus_wdata <= wdata_next;
                            bus_wen   <= mem_write;
                            bus_ren   <= ~mem_write;
                            busy      <= 1'b1;
                            lat_off   <= alu_result[1:0];
                            lat_size  <= size;
                            lat_uns   <= load_unsigned;
                            lat_read  <= ~mem_write;
                        end
                    end
                end
                REQ: begin
                    // An ack on the final allowed cycle still completes normally.
                    if (bus_ack) begin
                        state      <= DONE;
                        bus_ren    <= 1'b0;
                        bus_wen    <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        load_valid <= lat_read;
                        if (lat_read) begin
                            load_data <= load_ext;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state   <= IDLE;
                        bus_ren <= 1'b0;
                        bus_wen <= 1'b0;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic        bus_ren;
    logic        bus_wen;
    logic [31:0] load_data;
    logic        done;
    logic        load_valid;
    logic        err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .nrst(nrst),
        .alu_result(alu_result), .store_data(store_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .size(size), .load_unsigned(load_unsigned),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
        .bus_ren(bus_ren), .bus_wen(bus_wen),
        .load_data(load_data), .done(done), .load_valid(load_valid),
        .err(err), .busy(busy)
    );

    typedef struct {
        bit          d;
        bit          e;
        bit          lv;
        logic [31:0] ld;
        int          nren;
        int          nwen;
        int          lat;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(bit d, bit e, bit lv, logic [31:0] ld, int nren, int nwen, int lat,
                                logic [31:0] addr, logic [3:0] sel, logic [31:0] wdata);
        exp_t x;
        x.d = d; x.e = e; x.lv = lv; x.ld = ld; x.nren = nren; x.nwen = nwen; x.lat = lat;
        x.addr = addr; x.sel = sel; x.wdata = wdata;
        return x;
    endfunction

    // One transaction: strobe for one cycle, then watch each cycle (sampled at
    // negedge) until done/err, acking on the ack_at-th strobe cycle (0 = never).
    task automatic txn(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] sz, input logic uns,
                       input int ack_at, input logic [31:0] rdata, input exp_t ex);
        int nren = 0, nwen = 0, nbusy = 0, lat = -1;
        bit gd = 0, ge = 0, glv = 0, both = 0;
        logic [31:0] a = '0, w = '0, ld = '0;
        logic [3:0]  s = '0;
        exp_t e;
        sb_q.push_back(ex);
        @(negedge clk);
        mem_read = rd; mem_write = wr; alu_result = addr; store_data = data;
        size = sz; load_unsigned = uns; bus_ack = 1'b0;
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        alu_result = $urandom; store_data = $urandom; size = 2'($urandom); load_unsigned = ~uns;
        for (int i = 0; i < 20; i++) begin
            if (bus_ren && bus_wen) both = 1;
            if (busy) nbusy++;
            if (bus_ren) nren++;
            if (bus_wen) nwen++;
            if (bus_ren || bus_wen) begin a = bus_addr; s = bus_sel; w = bus_wdata; end
            bus_ack   = (bus_ren || bus_wen) && ((nren + nwen) == ack_at);
            bus_rdata = bus_ack ? rdata : $urandom;
            if (done || err) begin
                gd = done; ge = err; glv = load_valid; ld = load_data; lat = i;
                break;
            end
            @(negedge clk);
        end
        bus_ack = 1'b0;
        @(negedge clk);
        check({tag, " after"}, {28'b0, done, err, load_valid, busy}, 32'b0);
        e = sb_q.pop_front();
        check({tag, " done"}, 32'(gd), 32'(e.d));
        check({tag, " err"}, 32'(ge), 32'(e.e));
        check({tag, " load_valid"}, 32'(glv), 32'(e.lv));
        check({tag, " load_data"}, ld, e.ld);
        check({tag, " ren_cycles"}, 32'(nren), 32'(e.nren));
        check({tag, " wen_cycles"}, 32'(nwen), 32'(e.nwen));
        check({tag, " busy_cycles"}, 32'(nbusy), 32'(e.nren + e.nwen));
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " ren_and_wen"}, 32'(both), 32'b0);
        if (e.nren + e.nwen > 0) begin
            check({tag, " bus_addr"}, a, e.addr);
            check({tag, " bus_sel"}, {28'b0, s}, {28'b0, e.sel});
        end
        if (e.nwen > 0) check({tag, " bus_wdata"}, w, e.wdata);
    endtask

    initial begin
        bit seen;
        nrst = 1'b0; alu_result = '0; store_data = '0; mem_read = 1'b0; mem_write = 1'b0;
        size = 2'b00; load_unsigned = 1'b0; bus_rdata = '0; bus_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("reset outputs", {bus_ren, bus_wen, done, load_valid, err, busy, bus_sel}, 10'b0);
        check("reset bus_addr", bus_addr, 32'b0);
        check("reset bus_wdata", bus_wdata, 32'b0);
        check("reset load_data", load_data, 32'b0);
        nrst = 1'b1;

        txn("lw_100", 1, 0, 32'h100, 32'h0, 2'b10, 0, 1, 32'hDEADBEEF,
            mk(1, 0, 1, 32'hDEADBEEF, 1, 0, 1, 32'h100, 4'b1111, 32'h0));
        txn("lb_103", 1, 0, 32'h103, 32'h0, 2'b00, 0, 1, 32'h80FFFF7F,
            mk(1, 0, 1, 32'hFFFFFF80, 1, 0, 1, 32'h100, 4'b1000, 32'h0));
        txn("lbu_103", 1, 0, 32'h103, 32'h0, 2'b00, 1, 1, 32'h80FFFF7F,
            mk(1, 0, 1, 32'h00000080, 1, 0, 1, 32'h100, 4'b1000, 32'h0));
        txn("sh_202", 0, 1, 32'h202, 32'h0000ABCD, 2'b01, 0, 3, 32'h0,
            mk(1, 0, 0, 32'h00000080, 0, 3, 3, 32'h200, 4'b1100, 32'hABCDABCD));
        txn("lw_101", 1, 0, 32'h101, 32'h0, 2'b10, 0, 1, 32'h0,
            mk(0, 1, 0, 32'h00000080, 0, 0, 0, 32'h0, 4'b0, 32'h0));
        txn("lw_timeout", 1, 0, 32'h300, 32'h0, 2'b10, 0, 0, 32'h0,
            mk(0, 1, 0, 32'h00000080, 4, 0, 4, 32'h300, 4'b1111, 32'h0));
        txn("lh_502", 1, 0, 32'h502, 32'h0, 2'b01, 0, 2, 32'h80011234,
            mk(1, 0, 1, 32'hFFFF8001, 2, 0, 2, 32'h500, 4'b1100, 32'h0));
        txn("lhu_500", 1, 0, 32'h500, 32'h0, 2'b01, 1, 1, 32'h1234F00D,
            mk(1, 0, 1, 32'h0000F00D, 1, 0, 1, 32'h500, 4'b0011, 32'h0));
        txn("sb_601", 0, 1, 32'h601, 32'h12345678, 2'b00, 0, 1, 32'h0,
            mk(1, 0, 0, 32'h0000F00D, 0, 1, 1, 32'h600, 4'b0010, 32'h78787878));
        txn("size11", 0, 1, 32'h700, 32'h1, 2'b11, 0, 1, 32'h0,
            mk(0, 1, 0, 32'h0000F00D, 0, 0, 0, 32'h0, 4'b0, 32'h0));
        txn("sh_odd", 0, 1, 32'h0FF, 32'h1, 2'b01, 0, 1, 32'h0,
            mk(0, 1, 0, 32'h0000F00D, 0, 0, 0, 32'h0, 4'b0, 32'h0));
        txn("rd_wr_both", 1, 1, 32'h800, 32'hCAFEF00D, 2'b10, 0, 1, 32'h11111111,
            mk(1, 0, 0, 32'h0000F00D, 0, 1, 1, 32'h800, 4'b1111, 32'hCAFEF00D));
        txn("lb_900", 1, 0, 32'h900, 32'h0, 2'b00, 0, 1, 32'h11223344,
            mk(1, 0, 1, 32'h00000044, 1, 0, 1, 32'h900, 4'b0001, 32'h0));
        check("scoreboard empty", 32'(sb_q.size()), 32'd0);

        // bus_ack while IDLE must not produce any completion
        seen = 0;
        bus_ack = 1'b1; bus_rdata = 32'h55555555;
        repeat (3) begin
            @(negedge clk);
            if (done || load_valid || err || busy) seen = 1;
        end
        bus_ack = 1'b0;
        check("ack_in_idle", 32'(seen), 32'd0);
        check("ack_in_idle load_data", load_data, 32'h00000044);

        // reset during REQ aborts silently
        @(negedge clk);
        mem_read = 1'b1; alu_result = 32'h400; size = 2'b10; load_unsigned = 1'b0;
        @(negedge clk);
        mem_read = 1'b0;
        check("rst_mid ren before", {30'b0, bus_ren, busy}, 32'b11);
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        check("rst_mid after edge", {26'b0, bus_ren, bus_wen, busy, done, err, load_valid}, 32'b0);
        check("rst_mid load_data", load_data, 32'b0);
        nrst = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || err || bus_ren || busy) seen = 1;
        end
        check("rst_mid no pulse", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
